iob_cache_write_channel_axi_burst: RTL and testbench

IOB_CACHE_WRITE_CHANNEL_AXI_BURST -- requirements
Module: iob_cache_write_channel_axi_burst

---
 rtl/iob_cache_write_channel_axi_burst.sv | 180 ++++++++++++++++++
 tb/tb_iob_cache_write_channel_axi_burst.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_write_channel_axi_burst.sv
// Cache line write-back over an AXI4 INCR burst, with bounded retry on error responses.
module iob_cache_write_channel_axi_burst #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BE_ADDR_W = 32,
   parameter int unsigned BE_DATA_W = 32,
   parameter int unsigned LINE_W    = 128,
   parameter int unsigned AXI_ID_W  = 1,
   parameter int unsigned AXI_ID    = 0,
   parameter int unsigned AXI_LEN_W = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   // front-end line-write request
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [ADDR_W-1:0]        addr_i,
   input  logic [LINE_W-1:0]        wdata_i,
   output logic                     done_o,
   output logic                     err_o,
   output logic [3:0]               retry_cnt_o,
   // AXI write address channel
   output logic [AXI_ID_W-1:0]      axi_awid_o,
   output logic [BE_ADDR_W-1:0]     axi_awaddr_o,
   output logic [AXI_LEN_W-1:0]     axi_awlen_o,
   output logic [2:0]               axi_awsize_o,
   output logic [1:0]               axi_awburst_o,
   output logic [1:0]               axi_awlock_o,
   output logic [3:0]               axi_awcache_o,
   output logic [2:0]               axi_awprot_o,
   output logic [3:0]               axi_awqos_o,
   output logic                     axi_awvalid_o,
   input  logic                     axi_awready_i,
   // AXI write data channel
   output logic [BE_DATA_W-1:0]     axi_wdata_o,
   output logic [BE_DATA_W/8-1:0]   axi_wstrb_o,
   output logic                     axi_wlast_o,
   output logic                     axi_wvalid_o,
   input  logic                     axi_wready_i,
   // AXI write response channel
   input  logic [AXI_ID_W-1:0]      axi_bid_i,
   input  logic [1:0]               axi_bresp_i,
   input  logic                     axi_bvalid_i,
   output logic                     axi_bready_o
);

   localparam int unsigned N_BEATS = LINE_W / BE_DATA_W;
   localparam int unsigned BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int unsigned LINE_B  = LINE_W / 8;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(LINE_B - 1));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_data;
   logic [BEAT_W-1:0]   r_beat;
   logic                r_aw_done;
   logic                r_w_done;
   logic [3:0]          r_retry;
   logic                w_accept;
   logic                w_retry;
   logic                w_last;
   logic                w_aw_hs;
   logic                w_w_hs;
   logic                w_unused;

   // bid and the sub-line address bits carry no information for this block
   assign w_unused = ^{axi_bid_i, addr_i};

   // constant AW attributes and captured line address
   assign axi_awid_o    = AXI_ID_W'(AXI_ID);
   assign axi_awaddr_o  = BE_ADDR_W'(r_addr);
   assign axi_awlen_o   = AXI_LEN_W'(N_BEATS - 1);
   assign axi_awsize_o  = 3'($clog2(BE_DATA_W / 8));
   assign axi_awburst_o = (N_BEATS > 1) ? 2'b01 : 2'b00;
   assign axi_awlock_o  = 2'b00;
   assign axi_awcache_o = 4'b0011;
   assign axi_awprot_o  = 3'b000;
   assign axi_awqos_o   = 4'b0000;

   // current beat of the captured line
   assign w_last       = (r_beat == BEAT_W'(N_BEATS - 1));
   assign axi_wdata_o  = r_data[int'(r_beat) * BE_DATA_W +: BE_DATA_W];
   assign axi_wstrb_o  = '1;
   assign axi_wlast_o  = w_last;
   assign retry_cnt_o  = r_retry;

   assign w_aw_hs = axi_awvalid_o & axi_awready_i;
   assign w_w_hs  = axi_wvalid_o & axi_wready_i;

   // state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // next state, handshakes and completion strobes
   always_comb begin
      w_state_nxt   = r_state;
      ready_o       = 1'b0;
      axi_awvalid_o = 1'b0;
      axi_wvalid_o  = 1'b0;
      axi_bready_o  = 1'b0;
      done_o        = 1'b0;
      err_o         = 1'b0;
      w_accept      = 1'b0;
      w_retry       = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            axi_awvalid_o = ~r_aw_done;
            axi_wvalid_o  = ~r_w_done;
            // AW and W complete independently, in either order
            if ((r_aw_done | (~r_aw_done & axi_awready_i)) &&
                (r_w_done | (~r_w_done & axi_wready_i & w_last)))
               w_state_nxt = S_RESP;
         end
         S_RESP: begin
            axi_bready_o = 1'b1;
            if (axi_bvalid_i) begin
               if (axi_bresp_i == 2'b00) begin
                  done_o      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (r_retry < 4'(MAX_RETRY)) begin
                  w_retry     = 1'b1;
                  w_state_nxt = S_XFER;
               end else begin
                  done_o      = 1'b1;
                  err_o       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // request capture, beat/AW progress and retry bookkeeping
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_addr    <= '0;
         r_data    <= '0;
         r_beat    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_retry   <= 4'd0;
      end else if (w_accept) begin
         r_addr    <= addr_i & ADDR_MASK;
         r_data    <= wdata_i;
         r_beat    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_retry   <= 4'd0;
      end else if (w_retry) begin
         r_beat    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_retry   <= r_retry + 4'd1;
      end else if (r_state == S_XFER) begin
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs) begin
            if (w_last) r_w_done <= 1'b1;
            else        r_beat   <= r_beat + BEAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_iob_cache_write_channel_axi_burst.sv
// Randomized bench for the cache line write channel, checked against a transaction-level model.
module tb_iob_cache_write_channel_axi_burst;

   localparam int N_BEATS   = 4;
   localparam int MAX_RETRY = 2;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          valid_i, ready_o;
   logic [31:0]   addr_i;
   logic [127:0]  wdata_i;
   logic          done_o, err_o;
   logic [3:0]    retry_cnt_o;
   logic [0:0]    awid;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst, awlock;
   logic [3:0]    awcache, awqos;
   logic [2:0]    awprot;
   logic          awvalid, awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wlast, wvalid, wready;
   logic [0:0]    bid;
   logic [1:0]    bresp;
   logic          bvalid, bready;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   iob_cache_write_channel_axi_burst #(
      .ADDR_W(32), .BE_ADDR_W(32), .BE_DATA_W(32), .LINE_W(128),
      .AXI_ID_W(1), .AXI_ID(0), .AXI_LEN_W(8), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .valid_i(valid_i), .ready_o(ready_o), .addr_i(addr_i), .wdata_i(wdata_i),
      .done_o(done_o), .err_o(err_o), .retry_cnt_o(retry_cnt_o),
      .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
      .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awlock_o(awlock),
      .axi_awcache_o(awcache), .axi_awprot_o(awprot), .axi_awqos_o(awqos),
      .axi_awvalid_o(awvalid), .axi_awready_i(awready),
      .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
      .axi_wvalid_o(wvalid), .axi_wready_i(wready),
      .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // one full line write; md: 0 all ready, 1 random, 2 AW held off 6 cycles, 3 wready toggles
   task automatic run_req(input int md, input logic [31:0] a, input logic [127:0] d, input int n_err);
      logic [31:0] beats [N_BEATS];
      logic [31:0] prev_data;
      logic [1:0]  resp;
      bit          pending, bhs, exp_done, prev_stall, finished;
      int          aw_cnt, w_cnt, attempt, cyc_att;
      for (int k = 0; k < N_BEATS; k++) beats[k] = 32'(d >> (32 * k));
      aw_cnt = 0; w_cnt = 0; attempt = 0; cyc_att = 0;
      prev_stall = 0; prev_data = '0; finished = 0;

      @(posedge clk); #1;
      valid_i = 1'b1; addr_i = a; wdata_i = d;
      #1;
      check("ready_idle", 128'(ready_o), 128'(1));

      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(posedge clk); #1;
         valid_i = 1'($urandom % 2);
         addr_i  = $urandom;
         wdata_i = {$urandom, $urandom, $urandom, $urandom};
         pending = (aw_cnt == 1) && (w_cnt == N_BEATS);
         case (md)
            0: begin awready = 1'b1; wready = 1'b1; end
            1: begin awready = 1'($urandom % 2); wready = 1'($urandom % 2); end
            2: begin awready = (cyc_att >= 6); wready = 1'b1; end
            default: begin awready = 1'b1; wready = (cyc_att % 2 == 0); end
         endcase
         resp   = (attempt < n_err) ? 2'($urandom_range(1, 3)) : 2'b00;
         bresp  = resp;
         bid    = 1'($urandom % 2);
         bvalid = pending && ((md == 1) ? ($urandom % 2 == 1) : 1'b1);
         #1;
         check("ready_busy", 128'(ready_o), 128'(0));
         check("awvalid", 128'(awvalid), 128'(!pending && aw_cnt == 0));
         check("wvalid", 128'(wvalid), 128'(!pending && w_cnt < N_BEATS));
         check("bready", 128'(bready), 128'(pending));
         check("retry_cnt", 128'(retry_cnt_o), 128'(attempt));
         bhs      = pending && bvalid;
         exp_done = bhs && (resp == 2'b00 || attempt == MAX_RETRY);
         check("done", 128'(done_o), 128'(exp_done));
         check("err", 128'(err_o), 128'(exp_done && resp != 2'b00));
         if (prev_stall && wvalid) check("w_stable", 128'(wdata), 128'(prev_data));
         prev_stall = wvalid && !wready;
         prev_data  = wdata;
         if (wvalid && wready && w_cnt < N_BEATS) begin
            check("wdata", 128'(wdata), 128'(beats[w_cnt]));
            check("wlast", 128'(wlast), 128'(w_cnt == N_BEATS - 1));
            check("wstrb", 128'(wstrb), 128'(4'hF));
            w_cnt++;
         end
         if (awvalid && awready) begin
            check("aw_fields",
                  128'({awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos}),
                  128'({1'b0, a & 32'hFFFF_FFF0, 8'd3, 3'd2, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000}));
            if (md == 2) check("aw_after_w", 128'(w_cnt), 128'(N_BEATS));
            aw_cnt++;
         end
         cyc_att++;
         if (bhs) begin
            if (exp_done) begin
               finished = 1;
            end else begin
               attempt++;
               aw_cnt = 0; w_cnt = 0; cyc_att = 0; prev_stall = 0;
            end
         end
      end
      if (!finished) check("timeout", 128'(0), 128'(1));

      @(posedge clk); #1;
      valid_i = 1'b0; bvalid = 1'b0;
      #1;
      check("ready_after", 128'(ready_o), 128'(1));
      check("done_after", 128'(done_o), 128'(0));
      check("retry_hold", 128'(retry_cnt_o), 128'(attempt));
      check("attempts", 128'(attempt), 128'((n_err < MAX_RETRY) ? n_err : MAX_RETRY));
   endtask

   initial begin
      reset_i = 1'b1; valid_i = 1'b0; addr_i = '0; wdata_i = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 128'(ready_o), 128'(1));
      check("rst_valids", 128'({awvalid, wvalid, bready}), 128'(0));
      check("rst_done_err", 128'({done_o, err_o}), 128'(0));
      check("rst_retry", 128'(retry_cnt_o), 128'(0));
      @(negedge clk);
      reset_i = 1'b0;

      // directed scenarios
      run_req(0, 32'h0000_1234, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 0);
      run_req(2, 32'hABCD_0018, {$urandom, $urandom, $urandom, $urandom}, 0);
      run_req(3, 32'h0000_0F0F, {$urandom, $urandom, $urandom, $urandom}, 0);
      run_req(0, 32'h8000_0040, {$urandom, $urandom, $urandom, $urandom}, 1);
      run_req(1, 32'h1357_9BDF, {$urandom, $urandom, $urandom, $urandom}, 3);

      // reset in the middle of a burst, after beat 1
      @(posedge clk); #1;
      valid_i = 1'b1; addr_i = 32'h0000_2000; wdata_i = {$urandom, $urandom, $urandom, $urandom};
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b1;
      #1;
      check("midrst_valids", 128'({awvalid, wvalid, bready}), 128'(0));
      check("midrst_ready", 128'(ready_o), 128'(1));
      check("midrst_done", 128'({done_o, err_o}), 128'(0));
      check("midrst_retry", 128'(retry_cnt_o), 128'(0));
      @(posedge clk); #1;
      check("midrst_done2", 128'(done_o), 128'(0));
      reset_i = 1'b0;
      run_req(0, 32'h0000_3004, {$urandom, $urandom, $urandom, $urandom}, 0);

      // randomized traffic
      for (int i = 0; i < 25; i++)
         run_req(1, $urandom, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
